// File: rtl/zeta_table_gen.sv
// Run-time NTT twiddle table writer: walks zeta_root^n for n = 1..2^S-1 and
// writes each power to bank floor(log2 k), offset k - 2^stage, where k = brv_S(n).
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module zeta_table_gen #(
    parameter int Q = 3329,
    parameter int S = `NTT_STAGE_CNT,
    parameter int W = `DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         zeta_root,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_en,
    output logic [$clog2(S)-1:0] wr_stage,
    output logic [S-2:0]         wr_addr,
    output logic [W-1:0]         wr_data
);

    localparam int SW = $clog2(S);
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W:0]   QW     = (W+1)'(Q);
    localparam logic [S-1:0] N_LAST = '1;

    typedef enum logic [1:0] {IDLE, MUL, WR, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   root, p, acc, acc_nxt;
    logic [S-1:0]   n, k;
    logic [BW-1:0]  bcnt;
    logic [SW-1:0]  stage_k;
    logic [S-2:0]   addr_k;
    logic [W:0]     dbl, sum;
    logic           mul_last;

    assign mul_last = (state == MUL) && (bcnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     if (bcnt == '0) state_nxt = WR;
            WR:      state_nxt = (n == N_LAST) ? DONE : MUL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        wr_en = (state == WR);
    end

    // k = brv_S(n); bank is the highest set bit of k, offset is the bits below it
    always_comb begin
        for (int i = 0; i < S; i++) k[i] = n[S-1-i];
        stage_k = '0;
        addr_k  = '0;
        for (int i = 0; i < S; i++) begin
            if (k[i]) begin
                stage_k = SW'(i);
                addr_k  = '0;
                for (int j = 0; j < S-1; j++)
                    if (j < i) addr_k[j] = k[j];
            end
        end
    end

    // One MSB-first step of p*root mod Q; every intermediate stays below 2Q
    always_comb begin
        dbl = {acc, 1'b0};
        if (dbl >= QW) dbl = dbl - QW;
        sum = dbl + (root[bcnt] ? {1'b0, p} : '0);
        acc_nxt = (sum >= QW) ? W'(sum - QW) : sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            root <= '0;
            p    <= '0;
            acc  <= '0;
            n    <= '0;
            bcnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    root <= zeta_root;
                    p    <= W'(1);
                    acc  <= '0;
                    n    <= S'(1);
                    bcnt <= BW'(W-1);
                end
                MUL: begin
                    acc  <= acc_nxt;
                    bcnt <= bcnt - BW'(1);
                    if (bcnt == '0) p <= acc_nxt;
                end
                WR: if (n != N_LAST) begin
                    n    <= n + S'(1);
                    acc  <= '0;
                    bcnt <= BW'(W-1);
                end
                default: ;
            endcase
        end
    end

    // Write payload is loaded on the last MUL cycle and cleared after WR
    always_ff @(posedge clk) begin
        if (rst || !mul_last) begin
            wr_stage <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_stage <= stage_k;
            wr_addr  <= addr_k;
            wr_data  <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_zeta_table_gen.sv
// Bench for zeta_table_gen at Kyber parameters: scoreboard of expected writes
// in generation order, full-table capture, busy-start, reset and back-to-back runs.
module tb_zeta_table_gen;

    localparam int Q   = 3329;
    localparam int S   = 7;
    localparam int W   = 12;
    localparam int PER = W + 1;
    localparam int NW  = (1 << S) - 1;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [W-1:0]  zeta_root;
    logic          busy, done, wr_en;
    logic [2:0]    wr_stage;
    logic [5:0]    wr_addr;
    logic [W-1:0]  wr_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    zeta_table_gen #(.Q(Q), .S(S), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .zeta_root(zeta_root),
        .busy(busy), .done(done), .wr_en(wr_en),
        .wr_stage(wr_stage), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int brv(input int v);
        int r = 0;
        for (int i = 0; i < S; i++) r |= ((v >> i) & 1) << (S - 1 - i);
        return r;
    endfunction

    function automatic int powmod(input int b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return int'(r);
    endfunction

    function automatic int stage_of(input int kk);
        for (int s = S - 1; s >= 0; s--) if ((kk >> s) != 0) return s;
        return 0;
    endfunction

    typedef struct { int stage; int addr; int data; int rel; } exp_t;
    typedef struct { int root; int n; int stage; int addr; int data; } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   log_stage[128], log_addr[128], log_data[128];
    int   wcnt[128], mem[128];

    task automatic run_op(input int root, input bit pulse_busy);
        int t0, rel, widx, kk;
        bit got_done;
        exp_t e;
        sb.delete();
        for (int n = 1; n <= NW; n++) begin
            kk = brv(n);
            e.stage = stage_of(kk);
            e.addr  = kk - (1 << e.stage);
            e.data  = powmod(root, n);
            e.rel   = n * PER;
            sb.push_back(e);
        end
        for (int i = 0; i < 128; i++) begin
            wcnt[i] = 0; mem[i] = -1;
            log_stage[i] = -1; log_addr[i] = -1; log_data[i] = -1;
        end
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        zeta_root = W'(root);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        widx = 0;
        got_done = 1'b0;
        while (!got_done) begin
            rel = cyc - t0;
            if (rel > NW * PER + 50) break;
            chk("busy_high", busy, 1);
            if (wr_en) begin
                widx++;
                if (sb.size() == 0) chk("extra_write", widx, NW);
                else begin
                    e = sb.pop_front();
                    chk("wr_stage", wr_stage, e.stage);
                    chk("wr_addr",  wr_addr,  e.addr);
                    chk("wr_data",  wr_data,  e.data);
                    chk("wr_time",  rel,      e.rel);
                end
                chk("data_lt_q", (wr_data < Q), 1);
                kk = (1 << wr_stage) + int'(wr_addr);
                if (kk < 128) begin wcnt[kk]++; mem[kk] = int'(wr_data); end
                if (widx < 128) begin
                    log_stage[widx] = int'(wr_stage);
                    log_addr[widx]  = int'(wr_addr);
                    log_data[widx]  = int'(wr_data);
                end
            end else begin
                chk("payload_zero", {wr_stage, wr_addr, wr_data}, 0);
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_time", rel, NW * PER + 1);
                chk("write_count", widx, NW);
            end
            if (pulse_busy && (rel inside {1, 6, 12, 13, 700, 1651, 1652})) begin
                zeta_root = W'(5);
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            zeta_root = W'(root);
        end
        chk("done_seen", got_done, 1);
        chk("busy_fall", busy, 0);
        chk("done_pulse", done, 0);
        for (int k2 = 1; k2 <= NW; k2++) begin
            chk("wr_once", wcnt[k2], 1);
            chk("table", mem[k2], powmod(root, brv(k2)));
        end
    endtask

    task automatic check_vecs(input int root);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].root == root) begin
                chk("vec_stage", log_stage[vecs[i].n], vecs[i].stage);
                chk("vec_addr",  log_addr[vecs[i].n],  vecs[i].addr);
                chk("vec_data",  log_data[vecs[i].n],  vecs[i].data);
            end
        end
    endtask

    task automatic run_rst(input int at_rel);
        int t0, nwr, nbusy;
        zeta_root = W'(17);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < at_rel) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        if (at_rel == 3 * PER) chk("pre_rst_wr", wr_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",  busy,     0);
        chk("rst_done",  done,     0);
        chk("rst_wr_en", wr_en,    0);
        chk("rst_stage", wr_stage, 0);
        chk("rst_addr",  wr_addr,  0);
        chk("rst_data",  wr_data,  0);
        nwr = 0; nbusy = 0;
        repeat (100) begin
            @(negedge clk);
            if (wr_en) nwr++;
            if (busy)  nbusy++;
        end
        chk("no_wr_after_rst",   nwr,   0);
        chk("no_busy_after_rst", nbusy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int nb;
        vecs[0] = '{17,   1,  6, 0, 17};
        vecs[1] = '{17,   2,  5, 0, 289};
        vecs[2] = '{17,   64, 0, 0, 1729};
        vecs[3] = '{17,   32, 1, 0, 2580};
        vecs[4] = '{17,   96, 1, 1, 3289};
        vecs[5] = '{1,    64, 0, 0, 1};
        vecs[6] = '{3312, 1,  6, 0, 3312};
        vecs[7] = '{3312, 2,  5, 0, 289};

        rst = 1'b1; start = 1'b0; zeta_root = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",  busy,     0);
        chk("reset_done",  done,     0);
        chk("reset_wr_en", wr_en,    0);
        chk("reset_stage", wr_stage, 0);
        chk("reset_addr",  wr_addr,  0);
        chk("reset_data",  wr_data,  0);
        rst = 1'b0;
        @(negedge clk);

        run_op(17, 1'b0);
        check_vecs(17);
        run_op(17, 1'b1);
        check_vecs(17);

        // rst and start together in IDLE: rst must win
        rst = 1'b1; start = 1'b1; zeta_root = W'(17);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || wr_en) nb++;
        end
        chk("rst_wins", nb, 0);

        run_rst(5);
        run_rst(3 * PER);
        run_op(17, 1'b0);
        check_vecs(17);

        run_op(1, 1'b0);
        check_vecs(1);
        run_op(3312, 1'b0);
        check_vecs(3312);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
